// File: rtl/multicycle_control_fsm.sv
// Moore control FSM for the multicycle RV32I core: sequences the shared ALU/memory datapath.
// Optional memory handshake (memReady input) is enabled by defining MULTICYCLE_MEM_READY_EN.
module multicycle_control_fsm #(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         opcode,
  input  logic               zero,
`ifdef MULTICYCLE_MEM_READY_EN
  input  logic               memReady,
`endif
  output logic               pcWrite,
  output logic               adrSrc,
  output logic               irWrite,
  output logic               memWrite,
  output logic               regWrite,
  output logic [1:0]         resultSrc,
  output logic [1:0]         aluSrcA,
  output logic [1:0]         aluSrcB,
  output logic [1:0]         aluOp,
  output logic [1:0]         immSrc,
  output logic               instrDone,
  output logic               illegalInstr,
  output logic [STATE_W-1:0] state
);

  if (STATE_W < 4) begin : g_bad_state_w
    $error("multicycle_control_fsm: STATE_W must be >= 4");
  end

  localparam logic [STATE_W-1:0] S_FETCH    = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_DECODE   = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_MEMADR   = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_MEMREAD  = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_MEMWB    = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_MEMWRITE = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_EXECR    = STATE_W'(6);
  localparam logic [STATE_W-1:0] S_EXECI    = STATE_W'(7);
  localparam logic [STATE_W-1:0] S_ALUWB    = STATE_W'(8);
  localparam logic [STATE_W-1:0] S_JAL      = STATE_W'(9);
  localparam logic [STATE_W-1:0] S_BEQ      = STATE_W'(10);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;

  logic       mem_ready;
  logic       pc_update;
  logic       branch;
  logic       ir_write;
  logic       mem_write;
  logic       reg_write;
  logic       instr_done;
  logic       illegal;
  logic       adr_src;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;

`ifdef MULTICYCLE_MEM_READY_EN
  assign mem_ready = memReady;
`else
  assign mem_ready = 1'b1;
`endif

  // State register; reset overrides any pending memory wait.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and raw Moore control decode.
  always_comb begin
    state_d    = state_q;
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    adr_src    = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;

    case (state_q)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_update = 1'b1;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) begin
          state_d = S_MEMWB;
        end
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_BEQ: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b01;
        branch     = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Immediate format follows the opcode directly, independent of state.
  always_comb begin
    immSrc = 2'b00;
    case (opcode)
      OP_SW:   immSrc = 2'b01;
      OP_BEQ:  immSrc = 2'b10;
      OP_JAL:  immSrc = 2'b11;
      default: immSrc = 2'b00;
    endcase
  end

  // Side-effecting strobes are masked while reset is held.
  assign pcWrite      = ~reset & (pc_update | (branch & zero));
  assign irWrite      = ~reset & ir_write;
  assign memWrite     = ~reset & mem_write;
  assign regWrite     = ~reset & reg_write;
  assign instrDone    = ~reset & instr_done;
  assign illegalInstr = ~reset & illegal;

  assign adrSrc    = adr_src;
  assign resultSrc = result_src;
  assign aluSrcA   = alu_src_a;
  assign aluSrcB   = alu_src_b;
  assign aluOp     = alu_op;
  assign state     = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: walks each instruction class cycle by cycle.
module tb_multicycle_control_fsm;

  logic       clk;
  logic       reset;
  logic [6:0] opcode;
  logic       zero;
`ifdef MULTICYCLE_MEM_READY_EN
  logic       memReady;
`endif
  logic       pcWrite, adrSrc, irWrite, memWrite, regWrite, instrDone, illegalInstr;
  logic [1:0] resultSrc, aluSrcA, aluSrcB, aluOp, immSrc;
  logic [3:0] state;
  logic [20:0] obs;

  int vectors;
  int errors;

  multicycle_control_fsm #(.STATE_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .zero         (zero),
`ifdef MULTICYCLE_MEM_READY_EN
    .memReady     (memReady),
`endif
    .pcWrite      (pcWrite),
    .adrSrc       (adrSrc),
    .irWrite      (irWrite),
    .memWrite     (memWrite),
    .regWrite     (regWrite),
    .resultSrc    (resultSrc),
    .aluSrcA      (aluSrcA),
    .aluSrcB      (aluSrcB),
    .aluOp        (aluOp),
    .immSrc       (immSrc),
    .instrDone    (instrDone),
    .illegalInstr (illegalInstr),
    .state        (state)
  );

  assign obs = {state, pcWrite, adrSrc, irWrite, memWrite, regWrite, resultSrc,
                aluSrcA, aluSrcB, aluOp, immSrc, instrDone, illegalInstr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pack one expected output vector in the same field order as obs.
  function automatic logic [20:0] ev(input logic [3:0] st, input logic pcw, input logic adr,
                                     input logic ir, input logic mw, input logic rw,
                                     input logic [1:0] rs, input logic [1:0] a,
                                     input logic [1:0] b, input logic [1:0] op,
                                     input logic [1:0] imm, input logic done, input logic ill);
    return {st, pcw, adr, ir, mw, rw, rs, a, b, op, imm, done, ill};
  endfunction

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset;
    logic [20:0] ex [0:2];
    ex[0] = ev(4'd0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 0, 0);
    ex[1] = ex[0];
    ex[2] = ev(4'd0, 1, 0, 1, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 0, 0);
    for (int i = 0; i < 3; i++) begin
      if (i < 2) tick();
      else begin
        reset = 1'b0;
        #1;
      end
      vectors++;
      if (obs !== ex[i]) begin
        errors++;
        $display("FAIL reset[%0d]: got %h want %h", i, obs, ex[i]);
      end
    end
  endtask

  task automatic test_lw;
    logic [20:0] ex [0:5];
    opcode = 7'b0000011;
    #1;
    ex[0] = ev(4'd0, 1, 0, 1, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 0, 0);
    ex[1] = ev(4'd1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0);
    ex[2] = ev(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0);
    ex[3] = ev(4'd3, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
    ex[4] = ev(4'd4, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0);
    ex[5] = ex[0];
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      vectors++;
      if (obs !== ex[i]) begin
        errors++;
        $display("FAIL lw[%0d]: got %h want %h", i, obs, ex[i]);
      end
    end
  endtask

  task automatic test_sw;
    logic [20:0] ex [0:4];
    opcode = 7'b0100011;
    #1;
    ex[0] = ev(4'd0, 1, 0, 1, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b01, 0, 0);
    ex[1] = ev(4'd1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 0, 0);
    ex[2] = ev(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 2'b01, 0, 0);
    ex[3] = ev(4'd5, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1, 0);
    ex[4] = ex[0];
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      vectors++;
      if (obs !== ex[i]) begin
        errors++;
        $display("FAIL sw[%0d]: got %h want %h", i, obs, ex[i]);
      end
    end
  endtask

  task automatic test_beq(input logic z);
    logic [20:0] ex [0:3];
    opcode = 7'b1100011;
    zero   = z;
    #1;
    ex[0] = ev(4'd0, 1, 0, 1, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0);
    ex[1] = ev(4'd1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 0, 0);
    ex[2] = ev(4'd10, z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 2'b10, 1, 0);
    ex[3] = ex[0];
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      vectors++;
      if (obs !== ex[i]) begin
        errors++;
        $display("FAIL beq_z%0d[%0d]: got %h want %h", z, i, obs, ex[i]);
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_alu;
    logic [20:0] ex [0:11];
    logic [6:0]  ops [0:2];
    ops[0] = 7'b0110011;
    ops[1] = 7'b0010011;
    ops[2] = 7'b1101111;
    // R-type, I-type, jal: FETCH, DECODE, EXEC/JAL, ALUWB each
    ex[0]  = ev(4'd0, 1, 0, 1, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 0, 0);
    ex[1]  = ev(4'd1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0);
    ex[2]  = ev(4'd6, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0);
    ex[3]  = ev(4'd8, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0);
    ex[4]  = ex[0];
    ex[5]  = ex[1];
    ex[6]  = ev(4'd7, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00, 0, 0);
    ex[7]  = ex[3];
    ex[8]  = ev(4'd0, 1, 0, 1, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b11, 0, 0);
    ex[9]  = ev(4'd1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b11, 0, 0);
    ex[10] = ev(4'd9, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 2'b11, 0, 0);
    ex[11] = ev(4'd8, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 1, 0);
    for (int i = 0; i < 12; i++) begin
      if (i > 0) tick();
      if (i % 4 == 0) begin
        opcode = ops[i / 4];
        #1;
      end
      vectors++;
      if (obs !== ex[i]) begin
        errors++;
        $display("FAIL alu[%0d]: got %h want %h", i, obs, ex[i]);
      end
    end
    tick();
    vectors++;
    if (state !== 4'd0) begin
      errors++;
      $display("FAIL alu_return: got state %0d want 0", state);
    end
  endtask

  task automatic test_illegal;
    logic [20:0] ex [0:2];
    opcode = 7'b1111111;
    #1;
    ex[0] = ev(4'd0, 1, 0, 1, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 0, 0);
    ex[1] = ev(4'd1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 0, 1);
    ex[2] = ex[0];
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      vectors++;
      if (obs !== ex[i]) begin
        errors++;
        $display("FAIL illegal[%0d]: got %h want %h", i, obs, ex[i]);
      end
    end
  endtask

  task automatic test_sw_reset;
    logic [20:0] ex [0:5];
    opcode = 7'b0100011;
    #1;
    ex[0] = ev(4'd0, 1, 0, 1, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b01, 0, 0);
    ex[1] = ev(4'd1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 0, 0);
    ex[2] = ev(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 2'b01, 0, 0);
    ex[3] = ex[2];
    ex[4] = ev(4'd0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b01, 0, 0);
    ex[5] = ex[0];
    for (int i = 0; i < 6; i++) begin
      if (i == 3) begin
        reset = 1'b1;
        #1;
      end else if (i == 5) begin
        reset = 1'b0;
        #1;
      end else if (i > 0) begin
        tick();
      end
      vectors++;
      if (obs !== ex[i]) begin
        errors++;
        $display("FAIL sw_reset[%0d]: got %h want %h", i, obs, ex[i]);
      end
    end
  endtask

`ifdef MULTICYCLE_MEM_READY_EN
  task automatic test_mem_ready;
    logic [20:0] hold_f, go_f, wait_w, done_w;
    int          mw_cycles;
    int          done_cnt;
    opcode   = 7'b0100011;
    memReady = 1'b0;
    #1;
    hold_f = ev(4'd0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b01, 0, 0);
    go_f   = ev(4'd0, 1, 0, 1, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b01, 0, 0);
    wait_w = ev(4'd5, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 0, 0);
    done_w = ev(4'd5, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1, 0);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (obs !== hold_f) begin
        errors++;
        $display("FAIL mr_fetch_hold[%0d]: got %h want %h", i, obs, hold_f);
      end
      if (i == 0) tick();
    end
    memReady = 1'b1;
    #1;
    vectors++;
    if (obs !== go_f) begin
      errors++;
      $display("FAIL mr_fetch_go: got %h want %h", obs, go_f);
    end
    tick();
    tick();
    tick();
    mw_cycles = 0;
    done_cnt  = 0;
    for (int i = 0; i < 4; i++) begin
      memReady = (i == 3);
      #1;
      if (memWrite === 1'b1) mw_cycles++;
      if (instrDone === 1'b1) done_cnt++;
      vectors++;
      if (obs !== ((i == 3) ? done_w : wait_w)) begin
        errors++;
        $display("FAIL mr_memwrite[%0d]: got %h want %h", i, obs, (i == 3) ? done_w : wait_w);
      end
      tick();
    end
    vectors++;
    if (mw_cycles != 4 || done_cnt != 1 || state !== 4'd0) begin
      errors++;
      $display("FAIL mr_counts: got memWrite %0d done %0d state %0d want 4 1 0",
               mw_cycles, done_cnt, state);
    end
  endtask
`endif

  initial begin
    vectors = 0;
    errors  = 0;
    reset   = 1'b1;
    opcode  = 7'b0000000;
    zero    = 1'b0;
`ifdef MULTICYCLE_MEM_READY_EN
    memReady = 1'b1;
`endif
    test_reset();
    test_lw();
    test_sw();
    test_beq(1'b1);
    test_beq(1'b0);
    test_alu();
    test_illegal();
    test_sw_reset();
`ifdef MULTICYCLE_MEM_READY_EN
    test_mem_ready();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
